// File: rtl/mc_cpu_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset core: opcodes, funct codes,
// FSM state encoding and ALU operation codes.
package mc_cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL = 6'h00;
    localparam logic [5:0] F_SRL = 6'h02;
    localparam logic [5:0] F_JR  = 6'h08;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_LUI = 3'd7
    } alu_op_e;

    // andi/ori take a zero-extended immediate; everything else sign-extends.
    function automatic logic [31:0] ext_imm(input logic [15:0] imm, input logic zero_ext);
        return zero_ext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port,
// register 0 reads as zero and ignores writes.
module mc_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != 5'd0)) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'h0 : regs_q[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'h0 : regs_q[raddr2];

endmodule

// File: rtl/mc_cpu_core.sv
// Multi-cycle MIPS-subset core (FETCH/DECODE/EXEC/MEM/WB) on one shared memory port.
// Define ILLEGAL_TRAP_EN to halt on unrecognised instructions instead of skipping them.
module mc_cpu_core
    import mc_cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              Clk,
    input  logic              Clrn,
    output logic              MemReq,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [31:0]       MemWdata,
    input  logic [31:0]       MemRdata,
    input  logic              MemReady,
    output logic              Halted,
    output logic [31:0]       PcOut,
    output logic [2:0]        StateOut
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] imm_q, imm_d;
    logic [31:0] alu_out_q, alu_out_d;
    logic [31:0] mdr_q, mdr_d;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm16;
    logic [25:0] jaddr;

    assign opcode = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign sa     = ir_q[10:6];
    assign funct  = ir_q[5:0];
    assign imm16  = ir_q[15:0];
    assign jaddr  = ir_q[25:0];

    logic        is_rtype, is_branch, use_imm, legal;
    alu_op_e     alu_op;
    logic [31:0] alu_b, alu_result;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, rf_rdata1, rf_rdata2;

    assign is_rtype  = (opcode == OP_RTYPE);
    assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
    assign use_imm   = !is_rtype && !is_branch;

    always_comb begin
        alu_op = ALU_ADD;
        legal  = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    F_ADD:   alu_op = ALU_ADD;
                    F_SUB:   alu_op = ALU_SUB;
                    F_AND:   alu_op = ALU_AND;
                    F_OR:    alu_op = ALU_OR;
                    F_SLT:   alu_op = ALU_SLT;
                    F_SLL:   alu_op = ALU_SLL;
                    F_SRL:   alu_op = ALU_SRL;
                    F_JR:    alu_op = ALU_ADD;
                    default: legal  = 1'b0;
                endcase
            end
            OP_J, OP_JAL:            alu_op = ALU_ADD;
            OP_BEQ, OP_BNE:          alu_op = ALU_SUB;
            OP_ADDI, OP_LW, OP_SW:   alu_op = ALU_ADD;
            OP_ANDI:                 alu_op = ALU_AND;
            OP_ORI:                  alu_op = ALU_OR;
            OP_LUI:                  alu_op = ALU_LUI;
            default:                 legal  = 1'b0;
        endcase
    end

    assign alu_b = use_imm ? imm_q : b_q;

    always_comb begin
        alu_result = 32'h0;
        case (alu_op)
            ALU_ADD: alu_result = a_q + alu_b;
            ALU_SUB: alu_result = a_q - alu_b;
            ALU_AND: alu_result = a_q & alu_b;
            ALU_OR:  alu_result = a_q | alu_b;
            ALU_SLT: alu_result = {31'b0, ($signed(a_q) < $signed(alu_b))};
            ALU_SLL: alu_result = alu_b << sa;
            ALU_SRL: alu_result = alu_b >> sa;
            ALU_LUI: alu_result = {imm16, 16'h0000};
            default: alu_result = 32'h0;
        endcase
    end

    mc_regfile u_rf (
        .clk    (Clk),
        .rst    (Clrn),
        .raddr1 (rs),
        .raddr2 (rt),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2),
        .we     (rf_we),
        .waddr  (rf_waddr),
        .wdata  (rf_wdata)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        imm_d     = imm_q;
        alu_out_d = alu_out_q;
        mdr_d     = mdr_q;
        rf_we     = 1'b0;
        rf_waddr  = rt;
        rf_wdata  = alu_out_q;
        case (state_q)
            FETCH: begin
                if (MemReady) begin
                    ir_d    = MemRdata;
                    pc_d    = pc_q + 32'd4;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                a_d     = rf_rdata1;
                b_d     = rf_rdata2;
                imm_d   = ext_imm(imm16, (opcode == OP_ANDI) || (opcode == OP_ORI));
                state_d = EXEC;
                if (!legal) begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = HALT;
`else
                    state_d = FETCH;
`endif
                end else if ((opcode == OP_J) || (opcode == OP_JAL)) begin
                    pc_d    = {pc_q[31:28], jaddr, 2'b00};
                    state_d = FETCH;
                    // pc_q already points past the jal, so it is the link value
                    if (opcode == OP_JAL) begin
                        rf_we    = 1'b1;
                        rf_waddr = 5'd31;
                        rf_wdata = pc_q;
                    end
                end else if (is_rtype && (funct == F_JR)) begin
                    pc_d    = rf_rdata1;
                    state_d = FETCH;
                end
            end
            EXEC: begin
                alu_out_d = alu_result;
                if (is_branch) begin
                    if ((alu_result == 32'h0) == (opcode == OP_BEQ)) begin
                        pc_d = pc_q + {imm_q[29:0], 2'b00};
                    end
                    state_d = FETCH;
                end else if ((opcode == OP_LW) || (opcode == OP_SW)) begin
                    state_d = MEM;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                if (MemReady) begin
                    if (opcode == OP_SW) begin
                        state_d = FETCH;
                    end else begin
                        mdr_d   = MemRdata;
                        state_d = WB;
                    end
                end
            end
            WB: begin
                rf_we    = 1'b1;
                rf_waddr = is_rtype ? rd : rt;
                rf_wdata = (opcode == OP_LW) ? mdr_q : alu_out_q;
                state_d  = FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            HALT: state_d = HALT;
`endif
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge Clk or posedge Clrn) begin
        if (Clrn) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            alu_out_q <= '0;
            mdr_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            imm_q     <= imm_d;
            alu_out_q <= alu_out_d;
            mdr_q     <= mdr_d;
        end
    end

    // Gating with Clrn drops a pending request the moment reset is asserted.
    always_comb begin
        MemReq   = 1'b0;
        MemWe    = 1'b0;
        MemAddr  = '0;
        MemWdata = 32'h0;
        if (!Clrn) begin
            if (state_q == FETCH) begin
                MemReq  = 1'b1;
                MemAddr = pc_q[ADDR_W-1:0];
            end else if (state_q == MEM) begin
                MemReq  = 1'b1;
                MemAddr = alu_out_q[ADDR_W-1:0];
                if (opcode == OP_SW) begin
                    MemWe    = 1'b1;
                    MemWdata = b_q;
                end
            end
        end
    end

`ifdef ILLEGAL_TRAP_EN
    assign Halted = (state_q == HALT);
`else
    assign Halted = 1'b0;
`endif

    assign PcOut    = pc_q;
    assign StateOut = state_q;

endmodule

// File: tb/tb_mc_cpu_core.sv
// Bench for mc_cpu_core: directed ALU table, hand-written control/memory sequences,
// and random programs checked against an instruction-level model.
module tb_mc_cpu_core;
    import mc_cpu_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        clrn = 1'b1;
    logic        mem_req, mem_we, mem_ready = 1'b0, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = 32'h0, pc_out;
    logic [2:0]  state_out;

    logic [31:0] mem [0:1023];
    int          vectors = 0, errors = 0;
    int          wait_n = 0, cur_wait = 0, stall_cnt = 0, stall_total = 0;
    bit          rand_wait = 1'b0, busy = 1'b0;
    logic [31:0] lat_addr, lat_wdata;
    logic        lat_we;

    always #5 clk = ~clk;

    mc_cpu_core #(.RESET_PC(RPC), .ADDR_W(32)) dut (
        .Clk      (clk),
        .Clrn     (clrn),
        .MemReq   (mem_req),
        .MemWe    (mem_we),
        .MemAddr  (mem_addr),
        .MemWdata (mem_wdata),
        .MemRdata (mem_rdata),
        .MemReady (mem_ready),
        .Halted   (halted),
        .PcOut    (pc_out),
        .StateOut (state_out)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", nm, got, exp);
        end
    endtask

    // Memory model: decides MemReady on the falling edge for the next rising edge.
    always @(negedge clk) begin
        if (clrn || !mem_req) begin
            mem_ready = 1'b0;
            busy      = 1'b0;
        end else begin
            if (!busy) begin
                busy      = 1'b1;
                lat_addr  = mem_addr;
                lat_we    = mem_we;
                lat_wdata = mem_wdata;
                cur_wait  = rand_wait ? int'($urandom_range(0, 3)) : wait_n;
                stall_cnt = 0;
            end else begin
                chk("stall_addr", mem_addr, lat_addr);
                chk("stall_we", {31'b0, mem_we}, {31'b0, lat_we});
                chk("stall_wdata", mem_wdata, lat_wdata);
            end
            if (stall_cnt >= cur_wait) begin
                mem_ready = 1'b1;
                mem_rdata = mem[mem_addr[11:2]];
                if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
                busy = 1'b0;
            end else begin
                mem_ready = 1'b0;
                stall_cnt++;
                stall_total++;
            end
        end
    end

    function automatic logic [31:0] r_ins(input logic [5:0] f, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sa);
        return {OP_RTYPE, rs, rt, rd, sa, f};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] reg_of(input int r);
        return dut.u_rf.regs_q[r];
    endfunction

    task automatic put(input logic [31:0] addr, input logic [31:0] data);
        mem[addr[11:2]] = data;
    endtask

    task automatic hold_rst();
        clrn = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1;
        clrn = 1'b0;
        stall_total = 0;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 15;
    vec_t tbl [NV];

    function automatic logic [31:0] gen_ins(input bit last);
        int          k   = $urandom_range(0, 13);
        logic [4:0]  rs  = 5'($urandom_range(0, 7));
        logic [4:0]  rt  = 5'($urandom_range(0, 7));
        logic [4:0]  rd  = 5'($urandom_range(0, 7));
        logic [4:0]  sa  = 5'($urandom_range(0, 31));
        logic [15:0] imm = 16'($urandom);
        logic [15:0] off = 16'(32'h800 + 4 * $urandom_range(0, 15));
        if (last && k == 13) k = 7;
        case (k)
            0:  return r_ins(F_ADD, rs, rt, rd, 5'd0);
            1:  return r_ins(F_SUB, rs, rt, rd, 5'd0);
            2:  return r_ins(F_AND, rs, rt, rd, 5'd0);
            3:  return r_ins(F_OR,  rs, rt, rd, 5'd0);
            4:  return r_ins(F_SLT, rs, rt, rd, 5'd0);
            5:  return r_ins(F_SLL, 5'd0, rt, rd, sa);
            6:  return r_ins(F_SRL, 5'd0, rt, rd, sa);
            7:  return i_ins(OP_ADDI, rs, rt, imm);
            8:  return i_ins(OP_ANDI, rs, rt, imm);
            9:  return i_ins(OP_ORI,  rs, rt, imm);
            10: return i_ins(OP_LUI, 5'd0, rt, imm);
            11: return i_ins(OP_LW, 5'd0, rt, off);
            12: return i_ins(OP_SW, 5'd0, rt, off);
            default: return i_ins(($urandom_range(0, 1) == 0) ? OP_BEQ : OP_BNE, rs, rt, 16'd1);
        endcase
    endfunction

    task automatic rand_test(input int nprog);
        localparam int LEN = 12;
        logic [31:0] prog [LEN];
        logic [31:0] rm [32];
        logic [31:0] dm [16];
        logic [31:0] ins, a, b, sx, zx, res, end_pc;
        logic [15:0] imm;
        int          lat, i, nxt, cyc;
        bit          done;
        for (int t = 0; t < nprog; t++) begin
            rand_wait = 1'b1;
            hold_rst();
            for (int k = 0; k < 16; k++) begin
                dm[k] = $urandom;
                put(32'h800 + 32'(4 * k), dm[k]);
            end
            for (int k = 0; k < LEN; k++) begin
                prog[k] = gen_ins(k == LEN - 1);
                put(RPC + 32'(4 * k), prog[k]);
            end
            // Instruction-level reference: architectural effect and cycle cost per instruction.
            for (int r = 0; r < 32; r++) rm[r] = 32'h0;
            lat = 0;
            i   = 0;
            while (i < LEN) begin
                ins = prog[i];
                imm = ins[15:0];
                sx  = {{16{imm[15]}}, imm};
                zx  = {16'h0, imm};
                a   = rm[ins[25:21]];
                b   = rm[ins[20:16]];
                nxt = i + 1;
                case (ins[31:26])
                    OP_RTYPE: begin
                        case (ins[5:0])
                            F_ADD:   res = a + b;
                            F_SUB:   res = a - b;
                            F_AND:   res = a & b;
                            F_OR:    res = a | b;
                            F_SLT:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                            F_SLL:   res = b << ins[10:6];
                            default: res = b >> ins[10:6];
                        endcase
                        rm[ins[15:11]] = res;
                        lat += 4;
                    end
                    OP_ADDI: begin rm[ins[20:16]] = a + sx; lat += 4; end
                    OP_ANDI: begin rm[ins[20:16]] = a & zx; lat += 4; end
                    OP_ORI:  begin rm[ins[20:16]] = a | zx; lat += 4; end
                    OP_LUI:  begin rm[ins[20:16]] = zx << 16; lat += 4; end
                    OP_LW:   begin rm[ins[20:16]] = dm[(sx - 32'h800) >> 2]; lat += 5; end
                    OP_SW:   begin dm[(sx - 32'h800) >> 2] = b; lat += 4; end
                    OP_BEQ:  begin if (a == b) nxt = i + 2; lat += 3; end
                    default: begin if (a != b) nxt = i + 2; lat += 3; end
                endcase
                rm[0] = 32'h0;
                i = nxt;
            end
            end_pc = RPC + 32'(4 * LEN);
            release_rst();
            cyc  = 0;
            done = 1'b0;
            while (!done && cyc < 1000) begin
                run(1);
                cyc++;
                if (state_out == FETCH && pc_out == end_pc) done = 1'b1;
            end
            chk("rand_done", {31'b0, done}, 32'd1);
            chk("rand_cycles", 32'(cyc), 32'(lat + stall_total));
            for (int r = 1; r < 8; r++) chk($sformatf("rand_reg%0d", r), reg_of(r), rm[r]);
            for (int k = 0; k < 16; k++) chk($sformatf("rand_dmem%0d", k), mem[(32'h800 >> 2) + k], dm[k]);
        end
        rand_wait = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{r_ins(F_ADD, 1, 2, 3, 0),  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
        tbl[1]  = '{r_ins(F_ADD, 1, 2, 3, 0),  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        tbl[2]  = '{r_ins(F_SUB, 1, 2, 3, 0),  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
        tbl[3]  = '{r_ins(F_AND, 1, 2, 3, 0),  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0};
        tbl[4]  = '{r_ins(F_OR,  1, 2, 3, 0),  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0};
        tbl[5]  = '{r_ins(F_SLT, 1, 2, 3, 0),  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        tbl[6]  = '{r_ins(F_SLT, 1, 2, 3, 0),  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[7]  = '{r_ins(F_SLT, 1, 2, 3, 0),  32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001};
        tbl[8]  = '{r_ins(F_SLL, 0, 2, 3, 4),  32'h1234_5678, 32'h8000_0001, 32'h0000_0010};
        tbl[9]  = '{r_ins(F_SRL, 0, 2, 3, 31), 32'h1234_5678, 32'h8000_0000, 32'h0000_0001};
        tbl[10] = '{i_ins(OP_ADDI, 1, 3, 16'hFFFF), 32'h0000_0005, 32'h0, 32'h0000_0004};
        tbl[11] = '{i_ins(OP_ANDI, 1, 3, 16'h8001), 32'hFFFF_FFFF, 32'h0, 32'h0000_8001};
        tbl[12] = '{i_ins(OP_ORI,  1, 3, 16'h8000), 32'h1234_0000, 32'h0, 32'h1234_8000};
        tbl[13] = '{i_ins(OP_LUI,  0, 3, 16'hABCD), 32'h0000_0000, 32'h0, 32'hABCD_0000};
        tbl[14] = '{r_ins(F_SUB, 1, 2, 3, 0),  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF};

        // Reset state and first fetch address
        hold_rst();
        chk("rst_pc", pc_out, RPC);
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_we", {31'b0, mem_we}, 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_halt", {31'b0, halted}, 32'd0);
        chk("rst_state", {29'b0, state_out}, {29'b0, FETCH});
        release_rst();
        #1;
        chk("first_req", {31'b0, mem_req}, 32'd1);
        chk("first_addr", mem_addr, RPC);

        // ALU sequence, zero-wait
        hold_rst();
        put(RPC + 0,  i_ins(OP_ADDI, 0, 1, 16'd5));
        put(RPC + 4,  i_ins(OP_ADDI, 0, 2, 16'hFFFD));
        put(RPC + 8,  r_ins(F_ADD, 1, 2, 3, 0));
        put(RPC + 12, r_ins(F_SLT, 2, 1, 4, 0));
        release_rst();
        run(4);
        chk("seq_pc4", pc_out, RPC + 4);
        chk("seq_r1", reg_of(1), 32'd5);
        run(12);
        chk("seq_r3", reg_of(3), 32'd2);
        chk("seq_r4", reg_of(4), 32'd1);
        chk("seq_pc16", pc_out, RPC + 16);
        chk("seq_state", {29'b0, state_out}, {29'b0, FETCH});

        // Store then load with three wait states per access
        wait_n = 3;
        hold_rst();
        put(RPC + 0, i_ins(OP_ADDI, 0, 1, 16'd5));
        put(RPC + 4, i_ins(OP_SW, 0, 1, 16'd8));
        put(RPC + 8, i_ins(OP_LW, 0, 5, 16'd8));
        release_rst();
        run(7);
        chk("ws_pc_after_addi", pc_out, RPC + 4);
        run(20);
        chk("ws_not_done", {29'b0, state_out}, {29'b0, WB});
        run(1);
        chk("ws_pc", pc_out, RPC + 12);
        chk("ws_state", {29'b0, state_out}, {29'b0, FETCH});
        chk("ws_r5", reg_of(5), 32'd5);
        chk("ws_mem", mem[2], 32'd5);
        wait_n = 0;

        // beq taken with offset -1 spins in place; bne not taken falls through
        hold_rst();
        put(RPC, i_ins(OP_BEQ, 0, 0, 16'hFFFF));
        release_rst();
        run(3);
        chk("beq_pc1", pc_out, RPC);
        chk("beq_addr1", mem_addr, RPC);
        run(3);
        chk("beq_pc2", pc_out, RPC);
        hold_rst();
        put(RPC, i_ins(OP_BNE, 0, 0, 16'd5));
        release_rst();
        run(3);
        chk("bne_pc", pc_out, RPC + 4);

        // jal / jr round trip
        hold_rst();
        put(RPC, {OP_JAL, 26'h10});
        put(32'h40, r_ins(F_JR, 31, 0, 0, 0));
        release_rst();
        run(2);
        chk("jal_pc", pc_out, 32'h40);
        chk("jal_r31", reg_of(31), RPC + 4);
        run(2);
        chk("jr_pc", pc_out, RPC + 4);

        // R0 stays zero
        hold_rst();
        put(RPC + 0, i_ins(OP_ADDI, 0, 0, 16'd7));
        put(RPC + 4, r_ins(F_ADD, 0, 0, 2, 0));
        release_rst();
        run(8);
        chk("r0_add", reg_of(2), 32'd0);

        // Illegal instruction
        hold_rst();
        put(RPC + 0, 32'hFC00_0000);
        put(RPC + 4, i_ins(OP_ADDI, 0, 1, 16'd9));
        release_rst();
        run(2);
`ifdef ILLEGAL_TRAP_EN
        chk("ill_halted", {31'b0, halted}, 32'd1);
        chk("ill_req", {31'b0, mem_req}, 32'd0);
        chk("ill_pc", pc_out, RPC + 4);
        run(6);
        chk("ill_stay", {31'b0, halted}, 32'd1);
        chk("ill_r1", reg_of(1), 32'd0);
`else
        chk("ill_halted", {31'b0, halted}, 32'd0);
        chk("ill_state", {29'b0, state_out}, {29'b0, FETCH});
        chk("ill_pc", pc_out, RPC + 4);
        run(4);
        chk("ill_r1", reg_of(1), 32'd9);
`endif

        // Reset asserted in the middle of a stalled load
        wait_n = 10;
        hold_rst();
        put(RPC, i_ins(OP_LW, 0, 1, 16'd8));
        put(32'h8, 32'hCAFE_0001);
        release_rst();
        run(15);
        chk("mr_state", {29'b0, state_out}, {29'b0, MEM});
        chk("mr_req_before", {31'b0, mem_req}, 32'd1);
        #2;
        clrn = 1'b1;
        #1;
        chk("mr_req_drop", {31'b0, mem_req}, 32'd0);
        chk("mr_pc", pc_out, RPC);
        wait_n = 0;
        release_rst();
        #1;
        chk("mr_restart_addr", mem_addr, RPC);
        run(5);
        chk("mr_r1", reg_of(1), 32'hCAFE_0001);

        // Directed ALU table
        for (int v = 0; v < NV; v++) begin
            hold_rst();
            put(RPC + 0,  i_ins(OP_LUI, 0, 1, tbl[v].a[31:16]));
            put(RPC + 4,  i_ins(OP_ORI, 1, 1, tbl[v].a[15:0]));
            put(RPC + 8,  i_ins(OP_LUI, 0, 2, tbl[v].b[31:16]));
            put(RPC + 12, i_ins(OP_ORI, 2, 2, tbl[v].b[15:0]));
            put(RPC + 16, tbl[v].ins);
            release_rst();
            run(20);
            chk($sformatf("alu_vec%0d", v), reg_of(3), tbl[v].exp);
        end

        rand_test(30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
